// File: rtl/penta_code_lock.sv
// Five-key sequential code lock with tick-based entry timeout and open window.
// Optional lockout after repeated failures when PENTA_LOCK_LOCKOUT_EN is defined.
module penta_code_lock #(
  parameter int          CODE_LEN      = 4,
  parameter logic [23:0] CODE          = 24'o00004321,
  parameter int          TICK_W        = 21,
  parameter int          TIMEOUT_TICKS = 8,
  parameter int          OPEN_TICKS    = 16,
  parameter int          LOCK_TRIES    = 3,
  parameter int          LOCK_TICKS    = 64
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [4:0] key_pulse,
  output logic       unlocked,
  output logic       err,
  output logic       entering,
  output logic [3:0] digit_cnt,
  output logic       locked_out
);

  localparam int TMAX1  = (TIMEOUT_TICKS > OPEN_TICKS) ? TIMEOUT_TICKS : OPEN_TICKS;
  localparam int TMAX   = (TMAX1 > LOCK_TICKS) ? TMAX1 : LOCK_TICKS;
  localparam int TCNT_W = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    OPEN  = 2'd2
`ifdef PENTA_LOCK_LOCKOUT_EN
    , LOCKOUT = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   presc_q;
  logic [TCNT_W-1:0]   tcnt_q;
  logic [3:0]          cnt_q, cnt_d;
  logic                mism_q, mism_d;
  logic                err_d, accept, m;
  logic                unlocked_q, err_q, entering_q, locked_q;
  logic                tick, valid;
  logic [2:0]          dig;
  logic [7:0][2:0]     code_arr;

  assign code_arr = CODE;
  assign tick     = &presc_q;
  assign valid    = $onehot(key_pulse);

  always_comb begin
    dig = '0;
    for (int i = 0; i < 5; i++)
      if (key_pulse[i]) dig = 3'(i);
  end

`ifdef PENTA_LOCK_LOCKOUT_EN
  logic [7:0] fails_q;
  wire        lock_hit = (fails_q == 8'(LOCK_TRIES));
`endif

  // Next-state: keys win over an entry timeout; in OPEN both a key and expiry go to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mism_d  = mism_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    m       = mism_q | (dig != code_arr[cnt_q[2:0]]);
    case (state_q)
      IDLE: begin
`ifdef PENTA_LOCK_LOCKOUT_EN
        if (lock_hit) state_d = LOCKOUT;
        else
`endif
        if (valid) begin
          state_d = ENTRY;
          cnt_d   = 4'd1;
          mism_d  = (dig != code_arr[0]);
          accept  = 1'b1;
        end
      end
      ENTRY: begin
        if (valid) begin
          accept = 1'b1;
          if (cnt_q == 4'(CODE_LEN - 1)) begin
            cnt_d   = '0;
            mism_d  = 1'b0;
            err_d   = m;
            state_d = m ? IDLE : OPEN;
          end else begin
            cnt_d  = cnt_q + 4'd1;
            mism_d = m;
          end
        end else if (tick && tcnt_q == TCNT_W'(TIMEOUT_TICKS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          mism_d  = 1'b0;
        end
      end
      OPEN: begin
        if (valid || (tick && tcnt_q == TCNT_W'(OPEN_TICKS - 1))) state_d = IDLE;
      end
`ifdef PENTA_LOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (tick && tcnt_q == TCNT_W'(LOCK_TICKS - 1)) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      tcnt_q     <= '0;
      cnt_q      <= '0;
      mism_q     <= 1'b0;
      unlocked_q <= 1'b0;
      err_q      <= 1'b0;
      entering_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mism_q  <= mism_d;
      // Restarting the prescaler on every transition keeps tick durations exact.
      if (accept || state_d != state_q) begin
        presc_q <= '0;
        tcnt_q  <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
        if (tick) tcnt_q <= tcnt_q + 1'b1;
      end
      unlocked_q <= (state_d == OPEN);
      entering_q <= (state_d == ENTRY);
      err_q      <= err_d;
`ifdef PENTA_LOCK_LOCKOUT_EN
      locked_q   <= (state_d == LOCKOUT);
`else
      locked_q   <= 1'b0;
`endif
    end
  end

`ifdef PENTA_LOCK_LOCKOUT_EN
  always_ff @(posedge sysclk) begin
    if (reset)
      fails_q <= '0;
    else if ((state_d == OPEN && state_q != OPEN) || (state_q == LOCKOUT && state_d == IDLE))
      fails_q <= '0;
    else if (err_d && !lock_hit)
      fails_q <= fails_q + 8'd1;
  end
`endif

  assign unlocked   = unlocked_q;
  assign err        = err_q;
  assign entering   = entering_q;
  assign digit_cnt  = cnt_q;
  assign locked_out = locked_q;

endmodule

// File: tb/tb_penta_code_lock.sv
// Directed bench for penta_code_lock with TICK_W=3 (tick every 8 cycles).
module tb_penta_code_lock;
  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic [4:0] key_pulse = '0;
  logic       unlocked, err, entering, locked_out;
  logic [3:0] digit_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct { string tag; int exp; } exp_t;
  exp_t sb[$];

  penta_code_lock #(.TICK_W(3)) dut (
    .sysclk(sysclk), .reset(reset), .key_pulse(key_pulse),
    .unlocked(unlocked), .err(err), .entering(entering),
    .digit_cnt(digit_cnt), .locked_out(locked_out)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Drive one key vector for one edge; expected outputs go through the scoreboard.
  task automatic press(input string tag, input logic [4:0] k, input int ecnt,
                       input int eent, input int eunl, input int eerr, input int elo);
    exp_t e;
    int   obs [5];
    sb.push_back('{{tag, ".cnt"}, ecnt});
    sb.push_back('{{tag, ".ent"}, eent});
    sb.push_back('{{tag, ".unl"}, eunl});
    sb.push_back('{{tag, ".err"}, eerr});
    sb.push_back('{{tag, ".lo"},  elo});
    key_pulse = k;
    @(negedge sysclk);
    key_pulse = '0;
    obs = '{int'(digit_cnt), int'(entering), int'(unlocked), int'(err), int'(locked_out)};
    for (int i = 0; i < 5; i++) begin
      e = sb.pop_front();
      chk(e.tag, obs[i], e.exp);
    end
  endtask

  function automatic logic [4:0] key(input int d);
    logic [4:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  task automatic enter_correct(input string tag);
    press({tag, "_k1"}, key(1), 1, 1, 0, 0, 0); idle(4);
    press({tag, "_k2"}, key(2), 2, 1, 0, 0, 0); idle(4);
    press({tag, "_k3"}, key(3), 3, 1, 0, 0, 0); idle(4);
    press({tag, "_k4"}, key(4), 0, 0, 1, 0, 0);
  endtask

  initial begin
    int n, errs;
    idle(3);
    chk("rst_unl", int'(unlocked), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ent", int'(entering), 0);
    chk("rst_cnt", int'(digit_cnt), 0);
    chk("rst_lo",  int'(locked_out), 0);
    reset = 1'b0;
    idle(2);

    // Correct code and exact open window
    enter_correct("ok");
    n = 1; errs = 0;
    while (unlocked && n < 400) begin
      @(negedge sysclk);
      if (err) errs++;
      if (unlocked) n++;
    end
    chk("open_len", n, 128);
    chk("open_err", errs, 0);
    idle(3);

    // Wrong code
    press("bad_k1", key(1), 1, 1, 0, 0, 0); idle(4);
    press("bad_k2", key(2), 2, 1, 0, 0, 0); idle(4);
    press("bad_k3", key(0), 3, 1, 0, 0, 0); idle(4);
    press("bad_k4", key(4), 0, 0, 0, 1, 0);
    idle(1);
    chk("bad_err_1cyc", int'(err), 0);
    chk("bad_unl", int'(unlocked), 0);
    idle(3);

    // Timeout after key 2
    press("to_k1", key(1), 1, 1, 0, 0, 0); idle(4);
    press("to_k2", key(2), 2, 1, 0, 0, 0);
    idle(62); idle(1);
    chk("to_ent63", int'(entering), 1);
    idle(1);
    chk("to_ent64", int'(entering), 0);
    chk("to_cnt", int'(digit_cnt), 0);
    press("to_k3", key(3), 1, 1, 0, 0, 0);
    press("to_k4", key(4), 2, 1, 0, 0, 0);
    idle(70);
    chk("to_done", int'(entering), 0);

    // Invalid multi-key does not restart the timeout
    press("inv_k1", key(1), 1, 1, 0, 0, 0);
    idle(9);
    press("inv_multi", 5'b00011, 1, 1, 0, 0, 0);
    idle(52); idle(1);
    chk("inv_ent63", int'(entering), 1);
    idle(1);
    chk("inv_ent64", int'(entering), 0);
    idle(2);

    // Relock from OPEN
    enter_correct("rl");
    idle(10);
    press("rl_key0", key(0), 0, 0, 0, 0, 0);
    idle(2);

    // Reset mid-entry
    press("rs_k1", key(1), 1, 1, 0, 0, 0);
    press("rs_k2", key(2), 2, 1, 0, 0, 0);
    reset = 1'b1;
    @(negedge sysclk);
    chk("rs_cnt", int'(digit_cnt), 0);
    chk("rs_ent", int'(entering), 0);
    chk("rs_unl", int'(unlocked), 0);
    reset = 1'b0;
    idle(2);
    press("rs_after", key(1), 1, 1, 0, 0, 0);
    idle(70);

`ifdef PENTA_LOCK_LOCKOUT_EN
    // Three wrong codes trigger lockout
    for (int t = 0; t < 3; t++) begin
      press("lk_a", key(0), 1, 1, 0, 0, 0);
      press("lk_b", key(0), 2, 1, 0, 0, 0);
      press("lk_c", key(0), 3, 1, 0, 0, 0);
      press("lk_d", key(0), 0, 0, 0, 1, 0);
      if (t < 2) idle(2);
    end
    idle(1);
    chk("lk_lo", int'(locked_out), 1);
    for (int d = 1; d <= 4; d++) press("lk_ign", key(d), 0, 0, 0, 0, 1);
    n = 5;
    while (locked_out && n < 800) begin
      @(negedge sysclk);
      if (locked_out) n++;
    end
    chk("lk_len", n, 512);
    idle(2);
    enter_correct("lk_ok");
    idle(140);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
